// File: rtl/core_mem_arb_pkg.sv
// Shared types and helpers for the core memory arbiter and its round-robin picker.
package core_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2,
        ACK  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Index width for n requesters; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_priority_pick
    import core_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant,
    output logic               any_req
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        grant   = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port among NUM_CORES requesters.
// Optional response watchdog enabled by defining ARB_WATCHDOG_EN.
module core_mem_arbiter
    import core_mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CORES-1:0]                  core_req,
    input  logic [NUM_CORES-1:0]                  core_we,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  core_wdata,
    output logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  core_rdata,
    output logic [NUM_CORES-1:0]                  core_ack,
    output logic [NUM_CORES-1:0]                  core_err,
    output logic                                  mem_cmd_valid,
    input  logic                                  mem_cmd_ready,
    output logic                                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0]                 mem_cmd_addr,
    output logic [DATA_WIDTH-1:0]                 mem_cmd_wdata,
    output logic [id_width(NUM_CORES)-1:0]        mem_cmd_id,
    input  logic                                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                 mem_rsp_rdata,
    input  logic                                  mem_rsp_err,
    output logic                                  busy
);

    localparam int ID_W = id_width(NUM_CORES);

    if (NUM_CORES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("core_mem_arbiter: NUM_CORES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e             state;
    logic [ID_W-1:0]        last_grant;
    logic [ID_W-1:0]        grant_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [ID_W-1:0]        pick_grant;
    logic                   pick_any;

    rr_priority_pick #(
        .NUM_REQ (NUM_CORES),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (core_req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any_req    (pick_any)
    );

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    // Cleared while in CMD so it always starts from zero on RSP entry.
    always_ff @(posedge clk) begin
        if (rst)               wd_cnt <= '0;
        else if (state == CMD) wd_cnt <= '0;
        else if (state == RSP) wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // NOTE: sequential state uses <= only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_CORES - 1);
            grant_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rdata <= '0;
            core_err   <= '0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant_q <= pick_grant;
                    we_q    <= core_we[pick_grant];
                    addr_q  <= core_addr[pick_grant];
                    wdata_q <= core_wdata[pick_grant];
                    state   <= CMD;
                end
                CMD: if (mem_cmd_ready) state <= RSP;
                RSP: begin
                    if (mem_rsp_valid) begin
                        core_rdata[grant_q] <= mem_rsp_rdata;
                        core_err[grant_q]   <= mem_rsp_err;
                        state               <= ACK;
                    end
`ifdef ARB_WATCHDOG_EN
                    else if (wd_expire) begin
                        core_rdata[grant_q] <= '0;
                        core_err[grant_q]   <= 1'b1;
                        state               <= ACK;
                    end
`endif
                end
                ACK: begin
                    last_grant <= grant_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        core_ack = '0;
        if (state == ACK) core_ack[grant_q] = 1'b1;
    end

    assign mem_cmd_valid = (state == CMD);
    assign mem_cmd_we    = we_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_wdata = wdata_q;
    assign mem_cmd_id    = grant_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed table, corner sequences, random vs. model.
module tb_core_mem_arbiter;

    localparam int NC  = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NC-1:0]          core_req;
    logic [NC-1:0]          core_we;
    logic [NC-1:0][AW-1:0]  core_addr;
    logic [NC-1:0][DW-1:0]  core_wdata;
    logic [NC-1:0][DW-1:0]  core_rdata;
    logic [NC-1:0]          core_ack;
    logic [NC-1:0]          core_err;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic                   mem_cmd_we;
    logic [AW-1:0]          mem_cmd_addr;
    logic [DW-1:0]          mem_cmd_wdata;
    logic [IDW-1:0]         mem_cmd_id;
    logic                   mem_rsp_valid;
    logic [DW-1:0]          mem_rsp_rdata;
    logic                   mem_rsp_err;
    logic                   busy;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_CORES      (NC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_ack      (core_ack),
        .core_err      (core_err),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_cmd_id    (mem_cmd_id),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: last value delivered to each core, and the rotation pointer.
    logic [DW-1:0] hold_rdata [NC];
    logic          hold_err   [NC];
    int            last_g;

    typedef struct {
        int          core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp_rd;
        logic        rsp_er;
        int          rdy_dly;
        int          rsp_dly;
        int          exp_id;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NC-1:0] r, input int last);
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (last + k) % NC;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        core_req = '0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < NC; c++) begin
            hold_rdata[c] = '0;
            hold_err[c]   = 1'b0;
        end
        last_g = NC - 1;
    endtask

    task automatic set_core(input int c, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        core_req[c]   = 1'b1;
        core_we[c]    = we;
        core_addr[c]  = addr;
        core_wdata[c] = wd;
    endtask

    // Runs one transaction from an IDLE sample where the requests are already driven.
    task automatic do_txn(input int exp_g, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rd, input logic er, input logic stray,
                          input logic drop_early, input logic [31:0] exp_rd, input logic exp_er);
        check("idle_busy", busy, 1'b0);
        step();
        check("cmd_valid", mem_cmd_valid, 1'b1);
        check("cmd_id", mem_cmd_id, exp_g);
        check("cmd_we", mem_cmd_we, core_we[exp_g]);
        check("cmd_addr", mem_cmd_addr, core_addr[exp_g]);
        check("cmd_wdata", mem_cmd_wdata, core_wdata[exp_g]);
        check("cmd_busy", busy, 1'b1);
        for (int k = 0; k < rdy_dly; k++) begin
            mem_cmd_ready = 1'b0;
            step();
            check("bp_valid", mem_cmd_valid, 1'b1);
            check("bp_addr", mem_cmd_addr, core_addr[exp_g]);
            check("bp_wdata", mem_cmd_wdata, core_wdata[exp_g]);
            check("bp_we", mem_cmd_we, core_we[exp_g]);
        end
        mem_cmd_ready = 1'b1;
        mem_rsp_valid = stray;
        mem_rsp_rdata = 32'h5A5A_0000;
        mem_rsp_err   = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check("rsp_no_valid", mem_cmd_valid, 1'b0);
        check("rsp_no_ack", core_ack, '0);
        if (drop_early) core_req[exp_g] = 1'b0;
        for (int k = 0; k < rsp_dly; k++) begin
            step();
            check("wait_no_ack", core_ack, '0);
            check("wait_no_valid", mem_cmd_valid, 1'b0);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rd;
        mem_rsp_err   = er;
        step();
        mem_rsp_valid = 1'b0;
        hold_rdata[exp_g] = exp_rd;
        hold_err[exp_g]   = exp_er;
        check("ack_vec", core_ack, NC'(1) << exp_g);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("rdata%0d", c), core_rdata[c], hold_rdata[c]);
            check($sformatf("err%0d", c), core_err[c], hold_err[c]);
        end
        core_req[exp_g] = 1'b0;
        step();
        check("post_ack_clear", core_ack, '0);
        check("post_ack_idle", busy, 1'b0);
        last_g = exp_g;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
        rst = 1'b1;

        vt[0] = '{2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 2, 32'hDEADBEEF, 1'b0};
        vt[1] = '{1, 1'b1, 32'h20, 32'h55AA, 32'h0, 1'b1, 0, 0, 1, 32'h0, 1'b1};
        vt[2] = '{0, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, 5, 0, 0, 32'h12345678, 1'b0};
        vt[3] = '{3, 1'b1, 32'hFFFF_FFFC, 32'hA5A5A5A5, 32'h0BADF00D, 1'b0, 2, 3, 3, 32'h0BADF00D, 1'b0};
        vt[4] = '{2, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b1, 0, 1, 2, 32'hCAFEF00D, 1'b1};

        apply_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_ack", core_ack, '0);
        check("rst_err", core_err, '0);
        check("rst_cmd_valid", mem_cmd_valid, 1'b0);
        check("rst_cmd_we", mem_cmd_we, 1'b0);
        check("rst_cmd_addr", mem_cmd_addr, '0);
        check("rst_cmd_wdata", mem_cmd_wdata, '0);
        check("rst_cmd_id", mem_cmd_id, '0);
        for (int c = 0; c < NC; c++) check($sformatf("rst_rdata%0d", c), core_rdata[c], '0);

        // Directed single-requester table.
        for (int i = 0; i < 5; i++) begin
            set_core(vt[i].core, vt[i].we, vt[i].addr, vt[i].wdata);
            do_txn(vt[i].exp_id, vt[i].rdy_dly, vt[i].rsp_dly, vt[i].rsp_rd, vt[i].rsp_er,
                   1'(i % 2), 1'b0, vt[i].exp_rd, vt[i].exp_er);
        end

        // All four at once after reset: 0,1,2,3 then 0 again.
        apply_reset();
        for (int c = 0; c < NC; c++) set_core(c, 1'(c & 1), 32'h1000 + 32'(c * 4), 32'hF0 + 32'(c));
        for (int c = 0; c < NC; c++) do_txn(c, 0, 0, 32'hAA00 + 32'(c), 1'b0, 1'b0, 1'b0, 32'hAA00 + 32'(c), 1'b0);
        core_req = '1;
        for (int c = 0; c < NC; c++) do_txn(c, 1, 0, 32'hBB00 + 32'(c), 1'b0, 1'b0, 1'b0, 32'hBB00 + 32'(c), 1'b0);

        // Request dropped mid-transaction is still completed and acked.
        set_core(3, 1'b0, 32'h300, 32'h0);
        do_txn(model_pick(core_req, last_g), 0, 2, 32'h33, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0);

        // Reset during RSP, then a stray response: no ack, priority back to core 0.
        apply_reset();
        set_core(0, 1'b0, 32'h10, 32'h0);
        do_txn(0, 0, 0, 32'h77, 1'b0, 1'b0, 1'b0, 32'h77, 1'b0);
        set_core(2, 1'b1, 32'h200, 32'h99);
        step();
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        check("pre_rst_in_rsp", busy, 1'b1);
        rst = 1'b1;
        core_req = '0;
        step();
        rst = 1'b0;
        for (int c = 0; c < NC; c++) begin
            hold_rdata[c] = '0;
            hold_err[c]   = 1'b0;
        end
        last_g = NC - 1;
        check("rst_rsp_busy", busy, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0BAD0;
        step();
        mem_rsp_valid = 1'b0;
        check("stray_no_ack", core_ack, '0);
        check("stray_busy", busy, 1'b0);
        check("stray_rdata", core_rdata[2], '0);
        set_core(0, 1'b0, 32'h44, 32'h0);
        set_core(1, 1'b0, 32'h48, 32'h0);
        do_txn(0, 0, 0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0);
        do_txn(1, 0, 0, 32'h2, 1'b0, 1'b0, 1'b0, 32'h2, 1'b0);

        // Randomised traffic against the rotation model.
        for (int t = 0; t < 40; t++) begin
            int g;
            logic [31:0] rd;
            logic er;
            for (int c = 0; c < NC; c++)
                if (!core_req[c] && $urandom_range(0, 2) != 0)
                    set_core(c, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (core_req == '0) set_core(int'($urandom_range(0, NC - 1)), 1'b0, $urandom, $urandom);
            g  = model_pick(core_req, last_g);
            rd = $urandom;
            er = ($urandom_range(0, 3) == 0);
            do_txn(g, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd, er,
                   1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), rd, er);
        end

`ifdef ARB_WATCHDOG_EN
        // Watchdog: no response -> error ack exactly TO cycles after RSP entry.
        begin
            int n;
            apply_reset();
            set_core(3, 1'b0, 32'h3C, 32'h0);
            step();
            mem_cmd_ready = 1'b1;
            step();
            mem_cmd_ready = 1'b0;
            n = 0;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (core_ack != '0) begin
                    n = k;
                    break;
                end
            end
            check("wd_latency", n, TO);
            check("wd_ack", core_ack, 4'b1000);
            check("wd_err", core_err[3], 1'b1);
            check("wd_rdata", core_rdata[3], '0);
            core_req = '0;
            step();
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'hFEED;
            step();
            mem_rsp_valid = 1'b0;
            check("wd_late_no_ack", core_ack, '0);
            check("wd_late_busy", busy, 1'b0);
            // Response in the limit cycle wins over the timeout.
            set_core(1, 1'b0, 32'h14, 32'h0);
            step();
            mem_cmd_ready = 1'b1;
            step();
            mem_cmd_ready = 1'b0;
            for (int k = 0; k < TO - 1; k++) begin
                step();
                check("wd_wait_no_ack", core_ack, '0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h600DCAFE;
            mem_rsp_err   = 1'b0;
            step();
            mem_rsp_valid = 1'b0;
            check("wd_edge_ack", core_ack, 4'b0010);
            check("wd_edge_rdata", core_rdata[1], 32'h600DCAFE);
            check("wd_edge_err", core_err[1], 1'b0);
            core_req = '0;
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
